// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the post-commit store buffer.
// Sizes, entry layout and small helpers used by the RTL and the bench.
package store_buffer_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SB_ENTRIES = 4;

  typedef logic [XLEN-1:0]                 vaddr_t;
  typedef logic [XLEN-1:0]                 data_t;
  typedef logic [$clog2(SB_ENTRIES)-1:0]   sb_idx_t;
  typedef logic [$clog2(SB_ENTRIES):0]     sb_cnt_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    vaddr_t    addr;
    data_t     data;
    mem_size_t size;
    logic      valid;
  } sb_entry_t;

  function automatic data_t size_data_mask(input mem_size_t size);
    case (size)
      MEM_B:   return 32'h0000_00FF;
      MEM_H:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] offset, input mem_size_t size);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return offset == 2'd3;
      MEM_W:   return offset != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Commit, dcache drain and load-probe signals of the store buffer.
// slave: the store buffer itself; master: the core/dcache side.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic      commit_valid_i;
  vaddr_t    commit_addr_i;
  data_t     commit_data_i;
  mem_size_t commit_size_i;
  logic      full_o;
  logic      empty_o;

  logic      dc_req_valid_o;
  vaddr_t    dc_req_addr_o;
  data_t     dc_req_data_o;
  mem_size_t dc_req_size_o;
  logic      dc_req_ready_i;

  logic      ld_valid_i;
  vaddr_t    ld_addr_i;
  mem_size_t ld_size_i;
  logic      ld_fwd_hit_o;
  data_t     ld_fwd_data_o;
  logic      ld_stall_o;

  modport slave (
    input  commit_valid_i, commit_addr_i, commit_data_i, commit_size_i,
    output full_o, empty_o,
    output dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_size_o,
    input  dc_req_ready_i,
    input  ld_valid_i, ld_addr_i, ld_size_i,
    output ld_fwd_hit_o, ld_fwd_data_o, ld_stall_o
  );

  modport master (
    output commit_valid_i, commit_addr_i, commit_data_i, commit_size_i,
    input  full_o, empty_o,
    input  dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_size_o,
    output dc_req_ready_i,
    output ld_valid_i, ld_addr_i, ld_size_i,
    input  ld_fwd_hit_o, ld_fwd_data_o, ld_stall_o
  );
endinterface

// File: rtl/store_buffer_sb_byte_mask.sv
// Byte-enable mask of an access within its 32-bit word.
// Bit n set means byte n of the word (addr[1:0]==n) is touched.
module sb_byte_mask
  import store_buffer_pkg::*;
(
  input  logic [1:0] offset,
  input  mem_size_t  size,
  output logic [3:0] mask
);

  always_comb begin
    mask = '0;
    case (size)
      MEM_B:   mask = 4'b0001 << offset;
      MEM_H:   mask = 4'b0011 << offset;
      MEM_W:   mask = 4'b1111;
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order circular queue drained to the dcache,
// with youngest-entry store-to-load forwarding and partial-overlap stall.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  store_buffer_if.slave  sb
);

  sb_entry_t  mem [SB_ENTRIES];
  sb_idx_t    head;
  sb_idx_t    tail;
  sb_cnt_t    count;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  logic [3:0] ent_mask [SB_ENTRIES];
  logic [3:0] ld_mask;
  logic       found;
  sb_idx_t    sel;
  sb_idx_t    idx;
  data_t      word;

  assign full  = (count == sb_cnt_t'(SB_ENTRIES));
  assign empty = (count == '0);
  assign push  = sb.commit_valid_i && !full;
  assign pop   = !empty && sb.dc_req_ready_i;

  assign sb.full_o         = full;
  assign sb.empty_o        = empty;
  assign sb.dc_req_valid_o = !empty;
  assign sb.dc_req_addr_o  = mem[head].addr;
  assign sb.dc_req_data_o  = mem[head].data;
  assign sb.dc_req_size_o  = mem[head].size;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < SB_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // push and pop never target the same slot: push is blocked when full,
      // pop is blocked when empty
      if (push) begin
        mem[tail] <= '{addr:  sb.commit_addr_i,
                       data:  sb.commit_data_i,
                       size:  sb.commit_size_i,
                       valid: 1'b1};
        tail      <= tail + sb_idx_t'(1);
      end
      if (pop) begin
        mem[head].valid <= 1'b0;
        head            <= head + sb_idx_t'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + sb_cnt_t'(1);
        2'b01:   count <= count - sb_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < SB_ENTRIES; g++) begin : g_ent_mask
    sb_byte_mask u_ent_mask (
      .offset (mem[g].addr[1:0]),
      .size   (mem[g].size),
      .mask   (ent_mask[g])
    );
  end

  sb_byte_mask u_ld_mask (
    .offset (sb.ld_addr_i[1:0]),
    .size   (sb.ld_size_i),
    .mask   (ld_mask)
  );

  // Walk from tail-1 back towards head; i==SB_ENTRIES revisits tail, which
  // is only a live entry (the oldest) when the buffer is full.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= SB_ENTRIES; i++) begin
      idx = tail - sb_idx_t'(i);
      if (!found && mem[idx].valid &&
          (mem[idx].addr[XLEN-1:2] == sb.ld_addr_i[XLEN-1:2]) &&
          ((ent_mask[idx] & ld_mask) != '0)) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sb.ld_fwd_hit_o  = 1'b0;
    sb.ld_stall_o    = 1'b0;
    sb.ld_fwd_data_o = '0;
    word             = '0;
    if (sb.ld_valid_i && found) begin
      if ((ent_mask[sel] & ld_mask) == ld_mask) begin
        sb.ld_fwd_hit_o  = 1'b1;
        word             = (mem[sel].data & size_data_mask(mem[sel].size))
                           << {mem[sel].addr[1:0], 3'b000};
        sb.ld_fwd_data_o = (word >> {sb.ld_addr_i[1:0], 3'b000})
                           & size_data_mask(sb.ld_size_i);
      end else begin
        sb.ld_stall_o = 1'b1;
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(sb.commit_valid_i && full));

  a_commit_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    sb.commit_valid_i |-> !misaligned(sb.commit_addr_i[1:0], sb.commit_size_i));

  a_load_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    sb.ld_valid_i |-> !misaligned(sb.ld_addr_i[1:0], sb.ld_size_i));

endmodule
